icache_dm: RTL and testbench

Direct-mapped, read-only instruction cache between the five-stage CPU's fetch stage and instruction memory.
- Hits return the instruction in the same cycle.
- Misses stall fetch while a refill FSM fetches the whole line, one word per memory handshake.
- Feeds the IF stage's instruction register and consumes words from the backing instruction memory.

---
 rtl/icache_dm.sv | 105 ++++++++++
 tb/tb_icache_dm.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with a word-by-word refill FSM.
// Hits are combinational; a miss stalls fetch until the whole line has been refilled.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    input  logic        invalidate_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_valid_i
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;

    logic [TAG_W-1:0] tag_arr [LINES];
    logic [31:0]      data_arr [LINES*WORDS];

    logic [OFF_W-1:0] a_word;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             hit, miss, last, fill;
    logic             unused_ok;

    assign a_word    = cpu_addr_i[2 +: OFF_W];
    assign a_idx     = cpu_addr_i[2+OFF_W +: IDX_W];
    assign a_tag     = cpu_addr_i[31:2+OFF_W+IDX_W];
    assign unused_ok = ^cpu_addr_i[1:0];

    assign hit  = (state_q == IDLE) && cpu_req_i && valid_q[a_idx] && (tag_arr[a_idx] == a_tag);
    assign miss = (state_q == IDLE) && cpu_req_i && !hit;
    assign last = (cnt_q == OFF_W'(WORDS-1));
    assign fill = (state_q == REFILL) && mem_valid_i && !invalidate_i;

    // Outputs are gated by rst_n so an asynchronous reset silences them before any edge.
    assign cpu_stall_o = rst_n && ((state_q == REFILL) || miss);
    assign cpu_rdata_o = (rst_n && hit) ? data_arr[{a_idx, a_word}] : '0;
    assign mem_req_o   = rst_n && (state_q == REFILL);
    assign mem_addr_o  = mem_req_o ? {miss_tag_q, miss_idx_q, cnt_q, 2'b00} : '0;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        miss_tag_d = miss_tag_q;
        miss_idx_d = miss_idx_q;
        cnt_d      = cnt_q;
        if (invalidate_i) begin
            valid_d = '0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (miss) begin
                miss_tag_d     = a_tag;
                miss_idx_d     = a_idx;
                valid_d[a_idx] = 1'b0;
                cnt_d          = '0;
                state_d        = REFILL;
            end
        end else if (mem_valid_i) begin
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                valid_d[miss_idx_q] = 1'b1;
                state_d             = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data_arr[{miss_idx_q, cnt_q}] <= mem_rdata_i;
            if (last) tag_arr[miss_idx_q] <= miss_tag_q;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed tests for icache_dm against a simple instruction memory model.
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        wait_mode;
    int          wcnt;
    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] xfer_log [$];
    logic [31:0] req_log [$];

    icache_dm dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .invalidate_i(invalidate),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata), .mem_valid_i(mem_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
    endfunction

    assign mem_rdata = mem_req ? mem_word(mem_addr) : 32'h0;
    assign mem_valid = mem_req && (!wait_mode || wcnt == 2);

    always @(posedge clk) begin
        wcnt <= (mem_req && !mem_valid) ? wcnt + 1 : 0;
        if (mem_req) req_log.push_back(mem_addr);
        if (mem_req && mem_valid) xfer_log.push_back(mem_addr);
    end

    // Called at a negedge; returns stall cycles and the delivered word, leaves at the next negedge.
    task automatic fetch(input logic [31:0] a, output int st, output logic [31:0] d);
        cpu_req = 1'b1; cpu_addr = a; st = 0; #1;
        while (cpu_stall && st < 100) begin
            st++;
            @(negedge clk); #1;
        end
        if (st >= 100) begin
            nvec++; nerr++;
            $display("FAIL fetch_timeout addr=%h stall never dropped", a);
        end
        d = cpu_rdata;
        @(negedge clk);
    endtask

    task automatic chk_fetch(input string nm, input logic [31:0] a, input int exp_st);
        int st; logic [31:0] d;
        fetch(a, st, d);
        nvec++;
        if (st !== exp_st) begin nerr++; $display("FAIL %s_stall addr=%h got=%0d exp=%0d", nm, a, st, exp_st); end
        nvec++;
        if (d !== mem_word(a)) begin nerr++; $display("FAIL %s_data addr=%h got=%h exp=%h", nm, a, d, mem_word(a)); end
    endtask

    task automatic pulse_invalidate();
        cpu_req = 1'b0; invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h0; invalidate = 1'b0; wait_mode = 1'b0;
        @(negedge clk); #1;
        nvec++; if (cpu_stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
        nvec++; if (cpu_rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata got=%h exp=0", cpu_rdata); end
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        nvec++; if (mem_addr !== 32'h0) begin nerr++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        xfer_log.delete();
        chk_fetch("cold", 32'h0, 5);
        nvec++;
        if (xfer_log.size() != 4) begin nerr++; $display("FAIL cold_nxfer got=%0d exp=4", xfer_log.size()); end
        else for (int i = 0; i < 4; i++) begin
            nvec++;
            if (xfer_log[i] !== 32'(4*i)) begin nerr++; $display("FAIL cold_addr%0d got=%h exp=%h", i, xfer_log[i], 32'(4*i)); end
        end
        chk_fetch("hit4", 32'h4, 0);
        chk_fetch("hitC", 32'hC, 0);
    endtask

    task automatic test_wait_states();
        wait_mode = 1'b1; req_log.delete();
        chk_fetch("wait", 32'h80, 13);
        nvec++;
        if (req_log.size() != 12) begin nerr++; $display("FAIL wait_nreq got=%0d exp=12", req_log.size()); end
        else for (int i = 0; i < 12; i++) begin
            nvec++;
            if (req_log[i] !== 32'h80 + 32'(4*(i/3))) begin nerr++; $display("FAIL wait_addr%0d got=%h exp=%h", i, req_log[i], 32'h80 + 32'(4*(i/3))); end
        end
        wait_mode = 1'b0;
        chk_fetch("wait_hit88", 32'h88, 0);
        chk_fetch("wait_hit8C", 32'h8C, 0);
    endtask

    task automatic test_conflict();
        chk_fetch("conf_hit0", 32'h0, 0);
        chk_fetch("conf_miss100", 32'h100, 5);
        chk_fetch("conf_hit104", 32'h104, 0);
        chk_fetch("conf_remiss0", 32'h0, 5);
    endtask

    task automatic test_invalidate();
        chk_fetch("inv_fill40", 32'h40, 5);
        chk_fetch("inv_hit40", 32'h40, 0);
        pulse_invalidate();
        chk_fetch("inv_remiss40", 32'h40, 5);
        cpu_req = 1'b1; cpu_addr = 32'h50;
        @(negedge clk);
        @(negedge clk);
        invalidate = 1'b1; #1;
        nvec++; if (mem_addr !== 32'h54) begin nerr++; $display("FAIL inv_word2_addr got=%h exp=00000054", mem_addr); end
        @(negedge clk);
        invalidate = 1'b0; #1;
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL inv_abort_mem_req got=%b exp=0", mem_req); end
        nvec++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL inv_abort_stall got=%b exp=1", cpu_stall); end
        xfer_log.delete();
        chk_fetch("inv_refill50", 32'h50, 5);
        nvec++; if (xfer_log.size() != 4) begin nerr++; $display("FAIL inv_refill_nxfer got=%0d exp=4", xfer_log.size()); end
        chk_fetch("inv_hit5C", 32'h5C, 0);
        cpu_req = 1'b1; cpu_addr = 32'h70; invalidate = 1'b1; #1;
        nvec++; if (cpu_stall !== 1'b1) begin nerr++; $display("FAIL inv_same_stall got=%b exp=1", cpu_stall); end
        @(negedge clk);
        invalidate = 1'b0; #1;
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL inv_same_no_refill got=%b exp=0", mem_req); end
        chk_fetch("inv_same_miss70", 32'h70, 5);
        chk_fetch("inv_after50", 32'h50, 5);
    endtask

    task automatic test_reset_mid();
        cpu_req = 1'b1; cpu_addr = 32'h60;
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rmid_mem_req got=%b exp=0", mem_req); end
        nvec++; if (cpu_stall !== 1'b0) begin nerr++; $display("FAIL rmid_stall got=%b exp=0", cpu_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        chk_fetch("rmid_miss0", 32'h0, 5);
        chk_fetch("rmid_miss50", 32'h50, 5);
    endtask

    task automatic test_loop();
        int st, misses, stalls; logic [31:0] d;
        pulse_invalidate();
        for (int p = 0; p < 2; p++) begin
            misses = 0; stalls = 0;
            for (int a = 0; a < 64; a += 4) begin
                fetch(32'(a), st, d);
                if (st > 0) misses++;
                stalls += st;
                nvec++;
                if (d !== mem_word(32'(a))) begin nerr++; $display("FAIL loop%0d_data addr=%h got=%h exp=%h", p, a, d, mem_word(32'(a))); end
            end
            nvec++; if (misses != (p == 0 ? 4 : 0)) begin nerr++; $display("FAIL loop%0d_misses got=%0d exp=%0d", p, misses, p == 0 ? 4 : 0); end
            nvec++; if (stalls != (p == 0 ? 20 : 0)) begin nerr++; $display("FAIL loop%0d_stalls got=%0d exp=%0d", p, stalls, p == 0 ? 20 : 0); end
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_wait_states();
        test_conflict();
        test_invalidate();
        test_reset_mid();
        test_loop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
